// File: rtl/trap_pkg.sv
// Shared definitions for the writeback trap sequencer: cause codes,
// wb_exc bit positions and the sequencer state encoding.
package trap_pkg;

  // Synchronous exception cause codes (mcause with interrupt bit clear)
  localparam logic [3:0] CAUSE_FETCH_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_FETCH_FAULT    = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT     = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT    = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;

  // Interrupt cause codes (mcause with interrupt bit set)
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  // Bit positions inside wb_exc
  localparam int EXC_W              = 9;
  localparam int EXC_FETCH_MISALIGN = 0;
  localparam int EXC_FETCH_FAULT    = 1;
  localparam int EXC_ILLEGAL        = 2;
  localparam int EXC_BREAKPOINT     = 3;
  localparam int EXC_LOAD_MISALIGN  = 4;
  localparam int EXC_LOAD_FAULT     = 5;
  localparam int EXC_STORE_MISALIGN = 6;
  localparam int EXC_STORE_FAULT    = 7;
  localparam int EXC_ECALL          = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    WFI      = 2'd2
  } state_t;

endpackage

// File: rtl/trap_priority.sv
// Combinational trap encoder: picks the winning interrupt or exception
// and produces its cause code. Interrupts always outrank exceptions.
module trap_priority
  import trap_pkg::*;
(
  input  logic             eip,
  input  logic             sip,
  input  logic             tip,
  input  logic [EXC_W-1:0] wb_exc,
  output logic             take,
  output logic             is_interrupt,
  output logic [3:0]       cause
);

  // Fixed-priority select: eip > sip > tip > fetch > illegal > ebreak >
  // ecall > misaligned ls > faulting ls
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    take         = 1'b1;
    is_interrupt = 1'b0;
    cause        = CAUSE_FETCH_MISALIGN;
    if (eip) begin
      is_interrupt = 1'b1;
      cause        = IRQ_MEI;
    end else if (sip) begin
      is_interrupt = 1'b1;
      cause        = IRQ_MSI;
    end else if (tip) begin
      is_interrupt = 1'b1;
      cause        = IRQ_MTI;
    end else if (wb_exc[EXC_FETCH_MISALIGN]) cause = CAUSE_FETCH_MISALIGN;
    else if (wb_exc[EXC_FETCH_FAULT])        cause = CAUSE_FETCH_FAULT;
    else if (wb_exc[EXC_ILLEGAL])            cause = CAUSE_ILLEGAL;
    else if (wb_exc[EXC_BREAKPOINT])         cause = CAUSE_BREAKPOINT;
    else if (wb_exc[EXC_ECALL])              cause = CAUSE_ECALL_M;
    else if (wb_exc[EXC_STORE_MISALIGN])     cause = CAUSE_STORE_MISALIGN;
    else if (wb_exc[EXC_LOAD_MISALIGN])      cause = CAUSE_LOAD_MISALIGN;
    else if (wb_exc[EXC_STORE_FAULT])        cause = CAUSE_STORE_FAULT;
    else if (wb_exc[EXC_LOAD_FAULT])         cause = CAUSE_LOAD_FAULT;
    else                                     take  = 1'b0;
  end

endmodule

// File: rtl/trap_control.sv
// Writeback-stage trap sequencer: retires, traps, executes MRET or parks
// in WFI for each instruction leaving writeback, pulses the CSR side-band
// and redirects fetch through a valid/ready handshake.
module trap_control
  import trap_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [XLEN-1:0]  wb_pc,
  input  logic [EXC_W-1:0] wb_exc,
  input  logic             wb_mret,
  input  logic             wb_wfi,
  input  logic             eip,
  input  logic             tip,
  input  logic             sip,
  input  logic [XLEN-1:0]  trap_vector,
  input  logic [XLEN-1:0]  mret_vector,
  output logic             retired,
  output logic             traped,
  output logic             mret,
  output logic [XLEN-1:0]  ecp,
  output logic [3:0]       trap_cause,
  output logic             interupt,
  output logic             flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready
);

  state_t           state;
  logic             accept;
  logic             take;
  logic             take_irq;
  logic [3:0]       take_cause;
  logic [EXC_W-1:0] exc_in;
  logic [XLEN-1:0]  wake_pc;

  assign wb_ready = (state == IDLE);
  assign accept   = wb_valid && wb_ready;

  // Exception flags only matter for an accepted instruction; while parked
  // in WFI the encoder must react to interrupts alone.
  assign exc_in = accept ? wb_exc : '0;

  trap_priority u_priority (
    .eip          (eip),
    .sip          (sip),
    .tip          (tip),
    .wb_exc       (exc_in),
    .take         (take),
    .is_interrupt (take_irq),
    .cause        (take_cause)
  );

  // Redirect request and squash follow the state directly, so an async
  // reset drops them without waiting for a clock edge.
  assign redirect_valid = (state == REDIRECT);
  assign flush          = redirect_valid || (accept && (take || wb_mret));

  // Sequencer FSM with registered CSR pulses and latched redirect target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      retired     <= 1'b0;
      traped      <= 1'b0;
      mret        <= 1'b0;
      interupt    <= 1'b0;
      ecp         <= '0;
      trap_cause  <= '0;
      redirect_pc <= RESET_PC;
      wake_pc     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; the defaults below make the pulses one cycle wide.
      retired  <= 1'b0;
      traped   <= 1'b0;
      mret     <= 1'b0;
      interupt <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (take) begin
              traped      <= 1'b1;
              interupt    <= take_irq;
              trap_cause  <= take_cause;
              ecp         <= wb_pc;
              redirect_pc <= trap_vector;
              state       <= REDIRECT;
            end else if (wb_mret) begin
              mret        <= 1'b1;
              retired     <= 1'b1;
              redirect_pc <= mret_vector;
              state       <= REDIRECT;
            end else if (wb_wfi) begin
              retired <= 1'b1;
              wake_pc <= wb_pc + XLEN'(4);
              state   <= WFI;
            end else begin
              retired <= 1'b1;
            end
          end
        end
        REDIRECT: begin
          if (redirect_ready) state <= IDLE;
        end
        WFI: begin
          if (take) begin
            traped      <= 1'b1;
            interupt    <= 1'b1;
            trap_cause  <= take_cause;
            ecp         <= wake_pc;
            redirect_pc <= trap_vector;
            state       <= REDIRECT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_control.sv
// Self-checking bench for trap_control: directed scenarios plus randomized
// instruction streams checked against a transaction-level reference model.
module tb_trap_control;

  localparam logic [31:0] RESET_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, wb_ready, wb_mret, wb_wfi;
  logic [31:0] wb_pc;
  logic [8:0]  wb_exc;
  logic        eip, tip, sip;
  logic [31:0] trap_vector, mret_vector;
  logic        retired, traped, mret, interupt, flush;
  logic [31:0] ecp, redirect_pc;
  logic [3:0]  trap_cause;
  logic        redirect_valid, redirect_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_control #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_exc(wb_exc),
    .wb_mret(wb_mret), .wb_wfi(wb_wfi),
    .eip(eip), .tip(tip), .sip(sip),
    .trap_vector(trap_vector), .mret_vector(mret_vector),
    .retired(retired), .traped(traped), .mret(mret),
    .ecp(ecp), .trap_cause(trap_cause), .interupt(interupt),
    .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  // Reference: which trap (if any) a set of pending events produces.
  function automatic void model_trap(input logic e, s, t, input logic [8:0] exc,
                                     output logic take, output logic irq,
                                     output logic [3:0] cause);
    int order [9];
    order = '{0, 1, 2, 3, 8, 6, 4, 7, 5};
    take = 1'b0; irq = 1'b0; cause = 4'd0;
    if (e || s || t) begin
      take = 1'b1; irq = 1'b1;
      cause = e ? 4'd11 : (s ? 4'd3 : 4'd7);
    end else begin
      for (int i = 8; i >= 0; i--) begin
        if (exc[order[i]]) begin
          take = 1'b1;
          cause = (order[i] == 8) ? 4'd11 : 4'(order[i]);
        end
      end
    end
  endfunction

  task automatic clear_inputs();
    wb_valid = 1'b0; wb_exc = '0; wb_mret = 1'b0; wb_wfi = 1'b0;
    eip = 1'b0; sip = 1'b0; tip = 1'b0;
  endtask

  // One instruction through writeback, including any WFI wait and redirect.
  task automatic run_txn(input string tag, input logic [31:0] pc, input logic [8:0] exc,
                         input logic m, input logic w, input logic e, input logic s,
                         input logic t, input int hold, input int wait_c,
                         input logic [2:0] wake);
    logic take, irq, redir, exp_retire;
    logic [3:0] cause;
    logic [31:0] tgt, wake_pc;
    model_trap(e, s, t, exc, take, irq, cause);
    redir = take || m;
    exp_retire = !take;
    tgt = take ? trap_vector : mret_vector;
    @(negedge clk);
    wb_valid = 1'b1; wb_pc = pc; wb_exc = exc; wb_mret = m; wb_wfi = w;
    eip = e; sip = s; tip = t;
    #1;
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL %s wb_ready got %0b exp 1", tag, wb_ready); end
    checks++; if (flush !== redir) begin errors++; $display("FAIL %s accept flush got %0b exp %0b", tag, flush, redir); end
    @(negedge clk);
    clear_inputs();
    trap_vector = $urandom; mret_vector = $urandom;
    checks++; if (traped !== take) begin errors++; $display("FAIL %s traped got %0b exp %0b", tag, traped, take); end
    checks++; if (retired !== exp_retire) begin errors++; $display("FAIL %s retired got %0b exp %0b", tag, retired, exp_retire); end
    checks++; if (mret !== (m && !take)) begin errors++; $display("FAIL %s mret got %0b exp %0b", tag, mret, m && !take); end
    checks++; if (interupt !== (take && irq)) begin errors++; $display("FAIL %s interupt got %0b exp %0b", tag, interupt, take && irq); end
    if (take) begin
      checks++; if (trap_cause !== cause) begin errors++; $display("FAIL %s trap_cause got %0d exp %0d", tag, trap_cause, cause); end
      checks++; if (ecp !== pc) begin errors++; $display("FAIL %s ecp got %h exp %h", tag, ecp, pc); end
    end
    if (!redir && w) begin
      wake_pc = pc + 32'd4;
      for (int i = 0; i < wait_c; i++) begin
        checks++; if (wb_ready !== 1'b0 || flush !== 1'b0 || redirect_valid !== 1'b0)
          begin errors++; $display("FAIL %s wfi hold ready/flush/rv got %0b%0b%0b exp 000", tag, wb_ready, flush, redirect_valid); end
        if (i > 0) begin
          checks++; if (retired !== 1'b0 || traped !== 1'b0)
            begin errors++; $display("FAIL %s wfi pulses got %0b%0b exp 00", tag, retired, traped); end
        end
        @(negedge clk);
      end
      {eip, sip, tip} = wake;
      model_trap(wake[2], wake[1], wake[0], 9'd0, take, irq, cause);
      tgt = trap_vector;
      #1;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL %s wfi wake flush got %0b exp 0", tag, flush); end
      @(negedge clk);
      clear_inputs();
      trap_vector = $urandom;
      checks++; if (traped !== 1'b1 || interupt !== 1'b1 || retired !== 1'b0)
        begin errors++; $display("FAIL %s wake traped/int/ret got %0b%0b%0b exp 110", tag, traped, interupt, retired); end
      checks++; if (trap_cause !== cause) begin errors++; $display("FAIL %s wake cause got %0d exp %0d", tag, trap_cause, cause); end
      checks++; if (ecp !== wake_pc) begin errors++; $display("FAIL %s wake ecp got %h exp %h", tag, ecp, wake_pc); end
      redir = 1'b1;
    end
    if (redir) begin
      for (int i = 0; i <= hold; i++) begin
        checks++; if (redirect_valid !== 1'b1 || flush !== 1'b1 || wb_ready !== 1'b0)
          begin errors++; $display("FAIL %s redirect rv/flush/ready got %0b%0b%0b exp 110", tag, redirect_valid, flush, wb_ready); end
        checks++; if (redirect_pc !== tgt) begin errors++; $display("FAIL %s redirect_pc got %h exp %h", tag, redirect_pc, tgt); end
        if (i > 0) begin
          checks++; if (traped !== 1'b0 || retired !== 1'b0 || mret !== 1'b0)
            begin errors++; $display("FAIL %s pulse width got %0b%0b%0b exp 000", tag, traped, retired, mret); end
        end
        if (i == hold) redirect_ready = 1'b1;
        @(negedge clk);
        trap_vector = $urandom; mret_vector = $urandom;
      end
      redirect_ready = 1'b0;
      checks++; if (redirect_valid !== 1'b0 || wb_ready !== 1'b1 || flush !== 1'b0)
        begin errors++; $display("FAIL %s after ready rv/ready/flush got %0b%0b%0b exp 010", tag, redirect_valid, wb_ready, flush); end
    end else begin
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL %s redirect_valid got %0b exp 0", tag, redirect_valid); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear_inputs(); redirect_ready = 1'b0;
    wb_pc = '0; trap_vector = 32'h80; mret_vector = '0;
    #12;
    checks++; if ({retired, traped, mret, interupt, flush, redirect_valid} !== 6'b0)
      begin errors++; $display("FAIL reset pulses got %b exp 000000", {retired, traped, mret, interupt, flush, redirect_valid}); end
    checks++; if (ecp !== 32'h0 || trap_cause !== 4'h0) begin errors++; $display("FAIL reset ecp/cause got %h/%0d exp 0/0", ecp, trap_cause); end
    checks++; if (redirect_pc !== RESET_PC) begin errors++; $display("FAIL reset redirect_pc got %h exp %h", redirect_pc, RESET_PC); end
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL reset wb_ready got %0b exp 1", wb_ready); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    wb_valid = 1'b1; wb_pc = 32'h40;
    #1;
    checks++; if (retired !== 1'b0) begin errors++; $display("FAIL b2b early retired got %0b exp 0", retired); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) wb_valid = 1'b0;
      wb_pc = wb_pc + 32'd4;
      checks++; if (retired !== (i < 3)) begin errors++; $display("FAIL b2b retired[%0d] got %0b exp %0b", i, retired, i < 3); end
      checks++; if (traped !== 1'b0 || mret !== 1'b0 || flush !== 1'b0)
        begin errors++; $display("FAIL b2b side pulses[%0d] got %0b%0b%0b exp 000", i, traped, mret, flush); end
    end
  endtask

  task automatic test_exception();
    trap_vector = 32'h80;
    run_txn("ecall_illegal", 32'h100, 9'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 3'b000);
  endtask

  task automatic test_irq_priority();
    trap_vector = 32'h80;
    run_txn("irq_prio", 32'h200, 9'h004, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 3'b000);
    run_txn("irq_sip_tip", 32'h204, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 3'b000);
  endtask

  task automatic test_mret();
    mret_vector = 32'h344;
    run_txn("mret", 32'h300, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 3'b000);
  endtask

  task automatic test_wfi();
    trap_vector = 32'h80;
    run_txn("wfi_wrap", 32'hFFFF_FFFC, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 10, 3'b001);
  endtask

  task automatic test_idle_irq();
    @(negedge clk);
    eip = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (traped !== 1'b0 || wb_ready !== 1'b1 || flush !== 1'b0)
        begin errors++; $display("FAIL idle_irq traped/ready/flush got %0b%0b%0b exp 010", traped, wb_ready, flush); end
    end
    eip = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    wb_valid = 1'b1; wb_pc = 32'h500; wb_exc = 9'h001;
    @(negedge clk);
    clear_inputs();
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL areset pre rv got %0b exp 1", redirect_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (redirect_valid !== 1'b0 || wb_ready !== 1'b1 || flush !== 1'b0 || traped !== 1'b0)
      begin errors++; $display("FAIL areset rv/ready/flush/traped got %0b%0b%0b%0b exp 0100", redirect_valid, wb_ready, flush, traped); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({retired, traped, mret, interupt} !== 4'b0 || redirect_pc !== RESET_PC)
      begin errors++; $display("FAIL areset after pulses %b pc %h exp 0000 %h", {retired, traped, mret, interupt}, redirect_pc, RESET_PC); end
  endtask

  task automatic test_random();
    logic [8:0] exc;
    logic [2:0] wake;
    for (int n = 0; n < 120; n++) begin
      exc = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(1, 511)) : 9'd0;
      wake = 3'($urandom_range(1, 7));
      run_txn("random", $urandom, exc,
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0),
              $urandom_range(0, 3), $urandom_range(1, 4), wake);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_exception();
    test_irq_priority();
    test_mret();
    test_wfi();
    test_idle_irq();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
